// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: PC source encodings and parameter defaults.
package fetch_pkg;

  localparam int unsigned XLEN_DEF         = 32;
  localparam logic [63:0] RESET_VECTOR_DEF = 64'h0;
  localparam int unsigned IALIGN_DEF       = 32;

  typedef enum logic [1:0] {
    PC_SEQ  = 2'b00,
    PC_BR   = 2'b01,
    PC_JALR = 2'b10,
    PC_RSVD = 2'b11
  } pc_src_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control/trap side to fetch unit bus: redirect requests in, fetch address and misalign report out.
interface pc_fetch_unit_if
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
);

  logic            Stall;
  logic [1:0]      PCSrc;
  logic [XLEN-1:0] PCTarget;
  logic [XLEN-1:0] JalrTarget;
  logic            Trap;
  logic [XLEN-1:0] TrapVector;
  logic            InstrReady;
  logic            FetchValid;
  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] PCPlus4;
  logic [XLEN-1:0] PCNext;
  logic            MisalignErr;
  logic [XLEN-1:0] MisalignAddr;

  modport master (
    output Stall, PCSrc, PCTarget, JalrTarget, Trap, TrapVector, InstrReady,
    input  FetchValid, PC, PCPlus4, PCNext, MisalignErr, MisalignAddr
  );

  modport slave (
    input  Stall, PCSrc, PCTarget, JalrTarget, Trap, TrapVector, InstrReady,
    output FetchValid, PC, PCPlus4, PCNext, MisalignErr, MisalignAddr
  );

endinterface

// File: rtl/pc_redirect_buffer.sv
// Holds a redirect that arrived while the PC could not advance; a pending trap
// is protected from being replaced by a later non-trap redirect.
module pc_redirect_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance,
  input  logic            req_valid,
  input  logic            req_trap,
  input  logic [XLEN-1:0] req_pc,
  output logic            pend_valid,
  output logic [XLEN-1:0] pend_pc
);

  logic pend_trap;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_trap  <= 1'b0;
      pend_pc    <= '0;
    end else if (advance) begin
      pend_valid <= 1'b0;
      pend_trap  <= 1'b0;
    end else if (req_valid && (req_trap || !pend_trap)) begin
      pend_valid <= 1'b1;
      pend_trap  <= req_trap;
      pend_pc    <= req_pc;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC register with prioritised next-PC select (trap, branch, JALR,
// pending redirect, PC+4), stall/backpressure hold and misaligned-target reporting.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter int unsigned     IALIGN       = IALIGN_DEF
) (
  input logic            clk,
  input logic            rst_n,
  pc_fetch_unit_if.slave bus
);

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] req_tgt;
  logic [XLEN-1:0] sel_tgt;
  logic [XLEN-1:0] mis_tgt;
  logic [XLEN-1:0] mis_addr;
  logic [XLEN-1:0] pend_pc;
  logic            fetch_valid;
  logic            advance;
  logic            br_mis;
  logic            jalr_mis;
  logic            req_valid;
  logic            req_trap;
  logic            mis_hit;
  logic            mis_err;
  logic            pend_valid;

  assign pc_plus4 = pc + XLEN'(4);
  assign jalr_tgt = bus.JalrTarget & ~XLEN'(1);
  assign advance  = fetch_valid & bus.InstrReady & ~bus.Stall;

  // JALR already has bit0 cleared, so only bit1 can violate 32-bit alignment.
  always_comb begin
    br_mis   = (IALIGN == 16) ? bus.PCTarget[0] : (bus.PCTarget[1] | bus.PCTarget[0]);
    jalr_mis = (IALIGN == 16) ? 1'b0 : jalr_tgt[1];
  end

  // Priority select; misaligned branch/JALR requests fall through to pending/PC+4.
  always_comb begin
    req_valid = 1'b0;
    req_trap  = 1'b0;
    req_tgt   = '0;
    mis_hit   = 1'b0;
    mis_tgt   = '0;
    sel_tgt   = pc_plus4;
    if (bus.Trap) begin
      req_valid = 1'b1;
      req_trap  = 1'b1;
      req_tgt   = bus.TrapVector;
    end else if (bus.PCSrc == PC_BR) begin
      if (br_mis) begin
        mis_hit = 1'b1;
        mis_tgt = bus.PCTarget;
      end else begin
        req_valid = 1'b1;
        req_tgt   = bus.PCTarget;
      end
    end else if (bus.PCSrc == PC_JALR) begin
      if (jalr_mis) begin
        mis_hit = 1'b1;
        mis_tgt = jalr_tgt;
      end else begin
        req_valid = 1'b1;
        req_tgt   = jalr_tgt;
      end
    end
    if (req_valid) begin
      sel_tgt = req_tgt;
    end else if (pend_valid) begin
      sel_tgt = pend_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_VECTOR;
      fetch_valid <= 1'b0;
      mis_err     <= 1'b0;
      mis_addr    <= '0;
    end else begin
      fetch_valid <= 1'b1;
      mis_err     <= mis_hit;
      if (advance) begin
        pc <= sel_tgt;
      end
      if (mis_hit) begin
        mis_addr <= mis_tgt;
      end
    end
  end

  pc_redirect_buffer #(
    .XLEN (XLEN)
  ) u_redirect_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .advance    (advance),
    .req_valid  (req_valid),
    .req_trap   (req_trap),
    .req_pc     (req_tgt),
    .pend_valid (pend_valid),
    .pend_pc    (pend_pc)
  );

  assign bus.FetchValid   = fetch_valid;
  assign bus.PC           = pc;
  assign bus.PCPlus4      = pc_plus4;
  assign bus.PCNext       = sel_tgt;
  assign bus.MisalignErr  = mis_err;
  assign bus.MisalignAddr = mis_addr;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: two instances (IALIGN=32 and IALIGN=16)
// driven with the same stimulus and compared against a behavioural model.
module tb_pc_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned XL = 32;
  localparam logic [31:0] RV = 32'h0000_1000;

  typedef struct packed {
    logic        rst_n;
    logic        stall;
    logic        ready;
    logic [1:0]  src;
    logic [31:0] ptgt;
    logic [31:0] jtgt;
    logic        trap;
    logic [31:0] tvec;
  } stim_t;

  typedef struct packed {
    logic        fv;
    logic [31:0] pc;
    logic        err;
    logic [31:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  pc_fetch_unit_if #(.XLEN(XL)) bus0 ();
  pc_fetch_unit_if #(.XLEN(XL)) bus1 ();

  pc_fetch_unit #(.XLEN(XL), .RESET_VECTOR(RV), .IALIGN(32)) dut0 (
    .clk (clk), .rst_n (rst_n), .bus (bus0)
  );
  pc_fetch_unit #(.XLEN(XL), .RESET_VECTOR(RV), .IALIGN(16)) dut1 (
    .clk (clk), .rst_n (rst_n), .bus (bus1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit stim_done = 1'b0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference state per instance: fetch address, whether fetching has started,
  // and the one remembered redirect (with a flag saying it came from a trap).
  logic [31:0] m_pc [2];
  logic        m_fv [2];
  logic        m_pv [2];
  logic        m_pt [2];
  logic [31:0] m_pp [2];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp_v, $time);
  endfunction

  function automatic exp_t model_step(input int d, input stim_t s);
    exp_t        e;
    int unsigned bytes;
    logic [31:0] tgt, nxt, j, maddr;
    logic        hit, trap_req, mis, adv;
    bytes = (d == 0) ? 4 : 2;
    e = '0;
    if (!s.rst_n) begin
      m_pc[d] = RV; m_fv[d] = 1'b0; m_pv[d] = 1'b0; m_pt[d] = 1'b0; m_pp[d] = '0;
      e.pc = RV;
      return e;
    end
    adv = m_fv[d] && s.ready && !s.stall;
    hit = 1'b0; trap_req = 1'b0; mis = 1'b0; tgt = '0; maddr = '0;
    j = s.jtgt - (s.jtgt % 2);
    if (s.trap) begin
      hit = 1'b1; trap_req = 1'b1; tgt = s.tvec;
    end else if (s.src == 2'd1) begin
      if ((s.ptgt % bytes) != 0) begin mis = 1'b1; maddr = s.ptgt; end
      else begin hit = 1'b1; tgt = s.ptgt; end
    end else if (s.src == 2'd2) begin
      if ((j % bytes) != 0) begin mis = 1'b1; maddr = j; end
      else begin hit = 1'b1; tgt = j; end
    end
    if (hit) nxt = tgt;
    else if (m_pv[d]) nxt = m_pp[d];
    else nxt = m_pc[d] + 32'd4;
    if (adv) begin
      m_pc[d] = nxt; m_pv[d] = 1'b0; m_pt[d] = 1'b0;
    end else if (hit && (trap_req || !m_pt[d])) begin
      m_pv[d] = 1'b1; m_pp[d] = tgt; m_pt[d] = trap_req;
    end
    m_fv[d] = 1'b1;
    e.fv = 1'b1; e.pc = m_pc[d]; e.err = mis; e.addr = maddr;
    return e;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    s.ready = 1'b1;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    @(negedge clk);
    rst_n           = s.rst_n;
    bus0.Stall      = s.stall;  bus1.Stall      = s.stall;
    bus0.InstrReady = s.ready;  bus1.InstrReady = s.ready;
    bus0.PCSrc      = s.src;    bus1.PCSrc      = s.src;
    bus0.PCTarget   = s.ptgt;   bus1.PCTarget   = s.ptgt;
    bus0.JalrTarget = s.jtgt;   bus1.JalrTarget = s.jtgt;
    bus0.Trap       = s.trap;   bus1.Trap       = s.trap;
    bus0.TrapVector = s.tvec;   bus1.TrapVector = s.tvec;
    q0.push_back(model_step(0, s));
    q1.push_back(model_step(1, s));
  endtask

  task automatic check_dut(input string nm, input exp_t e, input logic fv, input logic [31:0] pc,
                           input logic [31:0] pc4, input logic err, input logic [31:0] addr);
    chk({nm, ".FetchValid"}, 32'(fv), 32'(e.fv));
    chk({nm, ".PC"}, pc, e.pc);
    chk({nm, ".PCPlus4"}, pc4, e.pc + 32'd4);
    chk({nm, ".MisalignErr"}, 32'(err), 32'(e.err));
    if (e.err) chk({nm, ".MisalignAddr"}, addr, e.addr);
  endtask

  // Monitor: each edge, the registered outputs are compared with the oldest expectation.
  initial begin
    exp_t e;
    while (!stim_done || q0.size() > 0 || q1.size() > 0) begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check_dut("dut0", e, bus0.FetchValid, bus0.PC, bus0.PCPlus4, bus0.MisalignErr, bus0.MisalignAddr);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check_dut("dut1", e, bus1.FetchValid, bus1.PC, bus1.PCPlus4, bus1.MisalignErr, bus1.MisalignAddr);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    rst_n = 1'b0;
    s = idle();
    s.rst_n = 1'b0;
    bus0.Stall = 1'b0; bus0.InstrReady = 1'b0; bus0.PCSrc = 2'b00; bus0.Trap = 1'b0;
    bus0.PCTarget = '0; bus0.JalrTarget = '0; bus0.TrapVector = '0;
    bus1.Stall = 1'b0; bus1.InstrReady = 1'b0; bus1.PCSrc = 2'b00; bus1.Trap = 1'b0;
    bus1.PCTarget = '0; bus1.JalrTarget = '0; bus1.TrapVector = '0;

    apply(s); apply(s);
    s = idle(); repeat (3) apply(s);
    s.src = 2'b01; s.ptgt = 32'h2000; apply(s);
    s = idle(); apply(s);
    s.src = 2'b10; s.jtgt = 32'h3001; apply(s);
    s.jtgt = 32'h3003; apply(s);
    s.src = 2'b01; s.ptgt = 32'h2002; apply(s);
    s = idle(); apply(s);
    s.stall = 1'b1; s.src = 2'b01; s.ptgt = 32'h4000; apply(s);
    s = idle(); s.stall = 1'b1; s.trap = 1'b1; s.tvec = 32'h80; apply(s);
    s = idle(); s.stall = 1'b1; s.src = 2'b01; s.ptgt = 32'h5000; apply(s);
    s = idle(); apply(s); apply(s);
    s.ready = 1'b0; apply(s); apply(s);
    s = idle(); s.trap = 1'b1; s.tvec = 32'h900; s.src = 2'b10; s.jtgt = 32'h7003; apply(s);
    s = idle(); s.src = 2'b11; s.ptgt = 32'h1234; apply(s);
    s = idle(); s.src = 2'b01; s.ptgt = 32'hFFFF_FFFC; apply(s);
    s = idle(); apply(s); apply(s);
    s.stall = 1'b1; s.src = 2'b01; s.ptgt = 32'h6000; apply(s);
    s = idle(); s.rst_n = 1'b0; apply(s);
    s = idle(); repeat (3) apply(s);

    for (int i = 0; i < 3000; i++) begin
      s = idle();
      s.rst_n = ($urandom_range(0, 149) != 0);
      s.stall = ($urandom_range(0, 3) == 0);
      s.ready = ($urandom_range(0, 3) != 0);
      s.src   = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
      s.ptgt  = $urandom();
      s.jtgt  = $urandom();
      if ($urandom_range(0, 1) == 0) s.ptgt = s.ptgt & 32'hFFFF_FFFC;
      if ($urandom_range(0, 1) == 0) s.jtgt = s.jtgt & 32'hFFFF_FFFD;
      if ($urandom_range(0, 15) == 0) s.ptgt = 32'hFFFF_FFF8 | (s.ptgt & 32'h4);
      s.trap  = ($urandom_range(0, 15) == 0);
      s.tvec  = $urandom() & 32'hFFFF_FFFC;
      apply(s);
    end
    s = idle();
    repeat (4) apply(s);
    stim_done = 1'b1;

    repeat (3) @(posedge clk);
    #2;
    chk("drain.q0", 32'(q0.size()), 32'd0);
    chk("drain.q1", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
